// File: rtl/useq_pkg.sv
// Shared definitions for the microprogram sequencer: sequencing opcodes.
package useq_pkg;

  localparam int SEQ_OP_W = 3;

  typedef enum logic [SEQ_OP_W-1:0] {
    NEXT  = 3'd0,
    JUMP  = 3'd1,
    CJUMP = 3'd2,
    MAP   = 3'd3,
    CALL  = 3'd4,
    RET   = 3'd5,
    FETCH = 3'd6,
    CCALL = 3'd7
  } seq_op_t;

endpackage

// File: rtl/useq_stack.sv
// Return-address LIFO for micro-subroutines. Push while full and pop while
// empty are ignored; the caller decides what an overflow/underflow means.
module useq_stack #(
  parameter int UADDR_W     = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic                             pop,
  input  logic [UADDR_W-1:0]               din,
  output logic [UADDR_W-1:0]               dout,
  output logic [$clog2(STACK_DEPTH+1)-1:0] level,
  output logic                             full,
  output logic                             empty
);

  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [UADDR_W-1:0] mem [STACK_DEPTH];
  logic [PTR_W-1:0]   wr_idx;
  logic [PTR_W-1:0]   rd_idx;
  logic [LVL_W-1:0]   level_dec;

  assign full      = (level == LVL_W'(STACK_DEPTH));
  assign empty     = (level == '0);
  assign level_dec = level - LVL_W'(1);
  assign wr_idx    = level[PTR_W-1:0];
  assign rd_idx    = level_dec[PTR_W-1:0];
  assign dout      = mem[rd_idx];

  // Occupancy counter; a simultaneous push and pop never occurs, push wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level <= '0;
    end else if (push && !full) begin
      level <= level + LVL_W'(1);
    end else if (pop && !empty) begin
      level <= level_dec;
    end
  end

  // Entry storage; contents are meaningless above level so they need no reset.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: selects and registers the next micro-address from
// the current microword's sequencing fields, with a call/return stack and a
// trap path for stack overflow/underflow.
module micro_sequencer #(
  parameter int          UADDR_W     = 8,
  parameter int          NFLAGS      = 4,
  parameter int          STACK_DEPTH = 4,
  parameter int unsigned FETCH_ADDR  = 0,
  parameter int unsigned TRAP_ADDR   = 2**UADDR_W - 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             stall,
  input  logic [2:0]                       seq_op,
  input  logic [$clog2(NFLAGS+1)-1:0]      cond_sel,
  input  logic                             cond_inv,
  input  logic [UADDR_W-1:0]               next_addr,
  input  logic [UADDR_W-1:0]               map_addr,
  input  logic [NFLAGS-1:0]                flags,
  output logic [UADDR_W-1:0]               uaddr,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_level,
  output logic                             err
);

  import useq_pkg::*;

  localparam int CSEL_W = $clog2(NFLAGS + 1);

  seq_op_t            op;
  logic               cond_raw;
  logic               cond;
  logic [UADDR_W-1:0] uaddr_inc;
  logic [UADDR_W-1:0] uaddr_nxt;
  logic               push;
  logic               pop;
  logic               stack_err;
  logic [UADDR_W-1:0] stack_top;
  logic               stack_full;
  logic               stack_empty;

  assign op        = seq_op_t'(seq_op);
  assign uaddr_inc = uaddr + UADDR_W'(1);

  // Condition mux: any index at or above NFLAGS reads as constant true.
  always_comb begin
    cond_raw = 1'b1;
    for (int i = 0; i < NFLAGS; i++) begin
      if (cond_sel == CSEL_W'(i)) cond_raw = flags[i];
    end
    cond = cond_raw ^ cond_inv;
  end

  // Next-address mux and stack requests; a full CALL or empty RET traps.
  always_comb begin
    uaddr_nxt = uaddr_inc;
    push      = 1'b0;
    pop       = 1'b0;
    stack_err = 1'b0;
    unique case (op)
      NEXT:  uaddr_nxt = uaddr_inc;
      JUMP:  uaddr_nxt = next_addr;
      CJUMP: uaddr_nxt = cond ? next_addr : uaddr_inc;
      MAP:   uaddr_nxt = map_addr;
      FETCH: uaddr_nxt = UADDR_W'(FETCH_ADDR);
      CALL, CCALL: begin
        if (op == CALL || cond) begin
          if (stack_full) begin
            uaddr_nxt = UADDR_W'(TRAP_ADDR);
            stack_err = 1'b1;
          end else begin
            uaddr_nxt = next_addr;
            push      = 1'b1;
          end
        end
      end
      RET: begin
        if (stack_empty) begin
          uaddr_nxt = UADDR_W'(TRAP_ADDR);
          stack_err = 1'b1;
        end else begin
          uaddr_nxt = stack_top;
          pop       = 1'b1;
        end
      end
      default: uaddr_nxt = uaddr_inc;
    endcase
  end

  useq_stack #(
    .UADDR_W     (UADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push && !stall),
    .pop   (pop && !stall),
    .din   (uaddr_inc),
    .dout  (stack_top),
    .level (stack_level),
    .full  (stack_full),
    .empty (stack_empty)
  );

  // Micro-address register; reset wins over stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uaddr <= UADDR_W'(FETCH_ADDR);
    end else if (!stall) begin
      uaddr <= uaddr_nxt;
    end
  end

  // Sticky stack-error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (!stall && stack_err) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_micro_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall;
  logic [2:0] seq_op;
  logic [2:0] cond_sel;
  logic       cond_inv;
  logic [7:0] next_addr;
  logic [7:0] map_addr;
  logic [3:0] flags;
  logic [7:0] uaddr;
  logic [2:0] stack_level;
  logic       err;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_u;
  int m_q[$];
  bit m_err;

  always #5 clk = ~clk;

  micro_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .seq_op      (seq_op),
    .cond_sel    (cond_sel),
    .cond_inv    (cond_inv),
    .next_addr   (next_addr),
    .map_addr    (map_addr),
    .flags       (flags),
    .uaddr       (uaddr),
    .stack_level (stack_level),
    .err         (err)
  );

  // One clock: drive a microword, advance the model, wait past the edge.
  task automatic step(input bit r_n, input bit st, input int op, input int na,
                      input int cs, input bit inv, input int fl, input int ma);
    bit c;
    int inc;
    @(negedge clk);
    rst_n = r_n; stall = st; seq_op = op[2:0]; next_addr = na[7:0];
    cond_sel = cs[2:0]; cond_inv = inv; flags = fl[3:0]; map_addr = ma[7:0];
    c   = ((cs >= 4) ? 1'b1 : fl[cs]) ^ inv;
    inc = (m_u + 1) % 256;
    if (!r_n) begin
      m_u = 0; m_q.delete(); m_err = 0;
    end else if (!st) begin
      if (op == 4 || (op == 7 && c)) begin
        if (m_q.size() == 4) begin m_u = 255; m_err = 1; end
        else begin m_q.push_back(inc); m_u = na; end
      end else if (op == 5) begin
        if (m_q.size() == 0) begin m_u = 255; m_err = 1; end
        else m_u = m_q.pop_back();
      end else if (op == 1) m_u = na;
      else if (op == 2) m_u = c ? na : inc;
      else if (op == 3) m_u = ma;
      else if (op == 6) m_u = 0;
      else m_u = inc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (uaddr !== 8'h00) begin failures++; $display("FAIL reset_uaddr got=%0h exp=0", uaddr); end
    checks++; if (stack_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", stack_level); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
  endtask

  task automatic test_next_wrap();
    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (uaddr !== 8'(i)) begin failures++; $display("FAIL next_%0d got=%0h exp=%0h", i, uaddr, i); end
    end
    step(1, 0, 1, 'hFF, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (uaddr !== 8'h00) begin failures++; $display("FAIL next_wrap got=%0h exp=0", uaddr); end
  endtask

  task automatic test_cjump();
    step(1, 0, 1, 'h20, 0, 0, 0, 0);
    step(1, 0, 2, 'h40, 1, 0, 'b0010, 0);
    checks++; if (uaddr !== 8'h40) begin failures++; $display("FAIL cjump_taken got=%0h exp=40", uaddr); end
    step(1, 0, 1, 'h20, 0, 0, 0, 0);
    step(1, 0, 2, 'h40, 1, 1, 'b0010, 0);
    checks++; if (uaddr !== 8'h21) begin failures++; $display("FAIL cjump_inv got=%0h exp=21", uaddr); end
    step(1, 0, 2, 'h40, 4, 0, 'b0000, 0);
    checks++; if (uaddr !== 8'h40) begin failures++; $display("FAIL cjump_true got=%0h exp=40", uaddr); end
    step(1, 0, 2, 'h55, 7, 0, 'b0000, 0);
    checks++; if (uaddr !== 8'h55) begin failures++; $display("FAIL cjump_sel_hi got=%0h exp=55", uaddr); end
    step(1, 0, 2, 'h10, 3, 0, 'b0111, 0);
    checks++; if (uaddr !== 8'h56) begin failures++; $display("FAIL cjump_not_taken got=%0h exp=56", uaddr); end
  endtask

  task automatic test_nesting();
    step(1, 0, 1, 'h10, 0, 0, 0, 0);
    step(1, 0, 4, 'h80, 0, 0, 0, 0);
    checks++; if (uaddr !== 8'h80 || stack_level !== 3'd1) begin failures++; $display("FAIL call1 got=%0h/%0d exp=80/1", uaddr, stack_level); end
    step(1, 0, 4, 'h90, 0, 0, 0, 0);
    checks++; if (uaddr !== 8'h90 || stack_level !== 3'd2) begin failures++; $display("FAIL call2 got=%0h/%0d exp=90/2", uaddr, stack_level); end
    step(1, 0, 5, 0, 0, 0, 0, 0);
    checks++; if (uaddr !== 8'h81 || stack_level !== 3'd1) begin failures++; $display("FAIL ret1 got=%0h/%0d exp=81/1", uaddr, stack_level); end
    step(1, 0, 5, 0, 0, 0, 0, 0);
    checks++; if (uaddr !== 8'h11 || stack_level !== 3'd0 || err !== 1'b0) begin failures++; $display("FAIL ret2 got=%0h/%0d/%0b exp=11/0/0", uaddr, stack_level, err); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_ret [4] = '{8'h41, 8'h31, 8'h21, 8'h11};
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 'h10, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 4, 'h20 + 'h10 * i, 0, 0, 0, 0);
    checks++; if (uaddr !== 8'h50 || stack_level !== 3'd4) begin failures++; $display("FAIL fill got=%0h/%0d exp=50/4", uaddr, stack_level); end
    step(1, 0, 7, 'h77, 0, 0, 'b0000, 0);
    checks++; if (uaddr !== 8'h51 || stack_level !== 3'd4 || err !== 1'b0) begin failures++; $display("FAIL ccall_untaken_full got=%0h/%0d/%0b exp=51/4/0", uaddr, stack_level, err); end
    step(1, 0, 4, 'h60, 0, 0, 0, 0);
    checks++; if (uaddr !== 8'hFF || stack_level !== 3'd4 || err !== 1'b1) begin failures++; $display("FAIL overflow got=%0h/%0d/%0b exp=ff/4/1", uaddr, stack_level, err); end
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 5, 0, 0, 0, 0, 0);
      checks++; if (uaddr !== exp_ret[i] || err !== 1'b1) begin failures++; $display("FAIL ret_%0d got=%0h/%0b exp=%0h/1", i, uaddr, err, exp_ret[i]); end
    end
    step(1, 0, 5, 0, 0, 0, 0, 0);
    checks++; if (uaddr !== 8'hFF || stack_level !== 3'd0 || err !== 1'b1) begin failures++; $display("FAIL underflow got=%0h/%0d/%0b exp=ff/0/1", uaddr, stack_level, err); end
    step(1, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (uaddr !== 8'h00 || err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0h/%0b exp=0/1", uaddr, err); end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear got=%0b exp=0", err); end
  endtask

  task automatic test_map_stall();
    step(1, 0, 4, 'h30, 0, 0, 0, 0);
    step(1, 0, 3, 0, 0, 0, 0, 'hCA);
    checks++; if (uaddr !== 8'hCA) begin failures++; $display("FAIL map got=%0h exp=ca", uaddr); end
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 4, 'h99, 0, 0, 0, 0);
      checks++; if (uaddr !== 8'hCA || stack_level !== 3'd1) begin failures++; $display("FAIL stall_%0d got=%0h/%0d exp=ca/1", i, uaddr, stack_level); end
    end
    step(0, 1, 4, 'h99, 0, 0, 0, 0);
    checks++; if (uaddr !== 8'h00 || stack_level !== 3'd0) begin failures++; $display("FAIL reset_over_stall got=%0h/%0d exp=0/0", uaddr, stack_level); end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 1, 'h10, 0, 0, 0, 0);
    step(1, 0, 4, 'h80, 0, 0, 0, 0);
    step(1, 0, 4, 'h90, 0, 0, 0, 0);
    checks++; if (stack_level !== 3'd2) begin failures++; $display("FAIL mid_level got=%0d exp=2", stack_level); end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (uaddr !== 8'h00 || stack_level !== 3'd0) begin failures++; $display("FAIL mid_reset got=%0h/%0d exp=0/0", uaddr, stack_level); end
    step(1, 0, 5, 0, 0, 0, 0, 0);
    checks++; if (uaddr !== 8'hFF || err !== 1'b1) begin failures++; $display("FAIL mid_abandon got=%0h/%0b exp=ff/1", uaddr, err); end
  endtask

  task automatic test_random();
    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(63) != 0), ($urandom_range(7) == 0), $urandom_range(7),
           $urandom_range(255), $urandom_range(7), $urandom_range(1),
           $urandom_range(15), $urandom_range(255));
      checks++;
      if (uaddr !== 8'(m_u) || stack_level !== 3'(m_q.size()) || err !== m_err) begin
        failures++;
        $display("FAIL random_%0d got=%0h/%0d/%0b exp=%0h/%0d/%0b", n, uaddr, stack_level, err, m_u, m_q.size(), m_err);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; seq_op = '0; cond_sel = '0; cond_inv = 1'b0;
    next_addr = '0; map_addr = '0; flags = '0;
    m_u = 0; m_err = 0;
    test_reset();
    test_next_wrap();
    test_cjump();
    test_nesting();
    test_overflow();
    test_map_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
